// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 8-bit five-stage pipeline.
// Drives pipeline register enables/flush/bubble and keeps stall/flush counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_halt,
    input  logic [3:0]  idex_reg_write_addr,
    input  logic        idex_reg_write_en,
    input  logic        idex_mem_to_reg,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        resume,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err_timeout,
    output logic [15:0] stall_cnt,
    output logic [7:0]  flush_cnt
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_DRAIN    = 3'd2,
        S_HALTED   = 3'd3
    } state_t;

    state_t     cur;
    logic [7:0] wait_cnt;
    logic [3:0] drain_cnt;
    logic       lu;
    logic       run_rules;
    logic [8:0] wait_next;

    assign state     = cur;
    assign halted    = (cur == S_HALTED);
    assign wait_next = {1'b0, wait_cnt} + 9'd1;

    // Load-use detect; MEM_WAIT with memory ready behaves exactly like RUN
    always_comb begin
        lu = idex_mem_to_reg & idex_reg_write_en &
             ((id_uses_rs1 & (id_rs1 == idex_reg_write_addr)) |
              (id_uses_rs2 & (id_rs2 == idex_reg_write_addr)));
        run_rules = (cur == S_RUN) | (cur == S_MEM_WAIT);
    end

    // Mealy pipeline controls from current state and hazard inputs
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (run_rules) begin
            if (mem_busy) begin
                pc_en = 1'b0;
            end else if (branch_taken) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else if (id_halt) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (lu) begin
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end else if (cur == S_DRAIN && !mem_busy) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end
    end

    // State, wait/drain counters, sticky timeout and saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= S_RUN;
            wait_cnt    <= 8'd0;
            drain_cnt   <= 4'd0;
            err_timeout <= 1'b0;
            stall_cnt   <= 16'd0;
            flush_cnt   <= 8'd0;
        end else begin
            unique case (cur)
                S_RUN, S_MEM_WAIT: begin
                    if (mem_busy) begin
                        if (stall_cnt != 16'hFFFF)
                            stall_cnt <= stall_cnt + 16'd1;
                        if (cur == S_RUN) begin
                            cur      <= S_MEM_WAIT;
                            wait_cnt <= 8'd1;
                        end else begin
                            if (wait_cnt != 8'hFF)
                                wait_cnt <= wait_next[7:0];
                            if (wait_next >= 9'(MEM_TIMEOUT)) begin
                                cur         <= S_HALTED;
                                err_timeout <= 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt <= 8'd0;
                        cur      <= S_RUN;
                        if (branch_taken) begin
                            if (flush_cnt != 8'hFF)
                                flush_cnt <= flush_cnt + 8'd1;
                        end else if (id_halt) begin
                            cur       <= S_DRAIN;
                            drain_cnt <= 4'd0;
                        end else if (lu) begin
                            if (stall_cnt != 16'hFFFF)
                                stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == 4'(DRAIN_CYCLES - 1))
                            cur <= S_HALTED;
                        else
                            drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                S_HALTED: begin
                    if (resume && !err_timeout)
                        cur <= S_RUN;
                end
                default: cur <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table for single-cycle
// RUN decisions plus directed multi-cycle sequences.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_halt;
    logic [3:0]  idex_reg_write_addr;
    logic        idex_reg_write_en;
    logic        idex_mem_to_reg;
    logic        branch_taken;
    logic        mem_busy;
    logic        resume;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_bubble;
    logic        exmem_en;
    logic        memwb_en;
    logic [2:0]  state;
    logic        halted;
    logic        err_timeout;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;
    logic [4:0]  en_v;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt),
        .idex_reg_write_addr(idex_reg_write_addr),
        .idex_reg_write_en(idex_reg_write_en),
        .idex_mem_to_reg(idex_mem_to_reg),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .state(state), .halted(halted), .err_timeout(err_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign en_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        u1;
        logic        u2;
        logic        halt;
        logic [3:0]  wa;
        logic        we;
        logic        m2r;
        logic        br;
        logic        busy;
        logic [4:0]  en;
        logic        fl;
        logic        bub;
        logic [2:0]  st;
        logic [15:0] sc;
        logic [7:0]  fc;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 4'd1; id_rs2 = 4'd2;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_halt = 1'b0;
        idex_reg_write_addr = 4'd5;
        idex_reg_write_en = 1'b0; idex_mem_to_reg = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; resume = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_lu();
        id_rs1 = 4'd5; id_uses_rs1 = 1'b1;
        idex_reg_write_addr = 4'd5;
        idex_reg_write_en = 1'b1; idex_mem_to_reg = 1'b1;
    endtask

    initial begin
        //        rs1   rs2   u1 u2 h  wa    we m2r br bz en        fl bub st    sc     fc
        tbl[0]  = '{4'd1, 4'd2, 1, 1, 0, 4'd5, 1, 0, 0, 0, 5'b11111, 0, 0, 3'd0, 16'd0, 8'd0};
        tbl[1]  = '{4'd1, 4'd5, 1, 1, 0, 4'd5, 1, 1, 0, 0, 5'b00111, 0, 1, 3'd0, 16'd1, 8'd0};
        tbl[2]  = '{4'd1, 4'd5, 1, 0, 0, 4'd5, 1, 1, 0, 0, 5'b11111, 0, 0, 3'd0, 16'd0, 8'd0};
        tbl[3]  = '{4'd5, 4'd2, 1, 0, 0, 4'd5, 1, 1, 0, 0, 5'b00111, 0, 1, 3'd0, 16'd1, 8'd0};
        tbl[4]  = '{4'd5, 4'd2, 1, 0, 0, 4'd5, 0, 1, 0, 0, 5'b11111, 0, 0, 3'd0, 16'd0, 8'd0};
        tbl[5]  = '{4'd5, 4'd2, 1, 0, 0, 4'd5, 1, 0, 0, 0, 5'b11111, 0, 0, 3'd0, 16'd0, 8'd0};
        tbl[6]  = '{4'd0, 4'd2, 1, 0, 0, 4'd0, 1, 1, 0, 0, 5'b00111, 0, 1, 3'd0, 16'd1, 8'd0};
        tbl[7]  = '{4'd5, 4'd2, 1, 0, 1, 4'd5, 1, 1, 1, 0, 5'b11111, 1, 1, 3'd0, 16'd0, 8'd1};
        tbl[8]  = '{4'd1, 4'd2, 0, 0, 1, 4'd5, 0, 0, 0, 0, 5'b01111, 1, 0, 3'd2, 16'd0, 8'd0};
        tbl[9]  = '{4'd5, 4'd2, 1, 0, 1, 4'd5, 1, 1, 0, 0, 5'b01111, 1, 0, 3'd2, 16'd0, 8'd0};
        tbl[10] = '{4'd5, 4'd2, 1, 0, 1, 4'd5, 1, 1, 1, 1, 5'b00000, 0, 0, 3'd1, 16'd1, 8'd0};

        idle();
        rst = 1'b1;

        // Reset behaviour
        cyc();
        chk("rst_en", 32'(en_v), 32'h00);
        chk("rst_flush", 32'(ifid_flush), 32'h1);
        chk("rst_bubble", 32'(idex_bubble), 32'h1);
        cyc();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_flushcnt", 32'(flush_cnt), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_en", 32'(en_v), 32'h1F);

        // Single-cycle RUN decisions
        for (int i = 0; i < 11; i++) begin
            reset_dut();
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
            id_halt = tbl[i].halt;
            idex_reg_write_addr = tbl[i].wa;
            idex_reg_write_en = tbl[i].we;
            idex_mem_to_reg = tbl[i].m2r;
            branch_taken = tbl[i].br; mem_busy = tbl[i].busy;
            #1;
            chk($sformatf("v%0d_en", i), 32'(en_v), 32'(tbl[i].en));
            chk($sformatf("v%0d_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
            chk($sformatf("v%0d_bubble", i), 32'(idex_bubble), 32'(tbl[i].bub));
            cyc();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].sc));
            chk($sformatf("v%0d_flushcnt", i), 32'(flush_cnt), 32'(tbl[i].fc));
        end

        // Load-use lasts one cycle only once the hazard clears
        reset_dut();
        set_lu();
        #1;
        chk("lu_en", 32'(en_v), 32'h07);
        cyc();
        idle();
        #1;
        chk("lu_after_en", 32'(en_v), 32'h1F);
        chk("lu_after_bub", 32'(idex_bubble), 32'h0);

        // Memory wait: 4 busy cycles then ready
        reset_dut();
        mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("mw_en_c%0d", i), 32'(en_v), 32'h00);
            cyc();
            chk($sformatf("mw_state_c%0d", i), 32'(state), 32'h1);
        end
        mem_busy = 1'b0;
        #1;
        chk("mw_en_c5", 32'(en_v), 32'h1F);
        chk("mw_stall", 32'(stall_cnt), 32'd4);
        cyc();
        chk("mw_state_c5", 32'(state), 32'h0);

        // Memory timeout after 15 busy cycles
        reset_dut();
        mem_busy = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (i == 14) begin
                chk("to_state_c14", 32'(state), 32'h1);
                chk("to_err_c14", 32'(err_timeout), 32'h0);
            end
        end
        chk("to_state", 32'(state), 32'h3);
        chk("to_err", 32'(err_timeout), 32'h1);
        chk("to_stall", 32'(stall_cnt), 32'd15);
        mem_busy = 1'b0;
        resume = 1'b1;
        #1;
        chk("to_halt_en", 32'(en_v), 32'h00);
        chk("to_halted", 32'(halted), 32'h1);
        cyc();
        cyc();
        chk("to_resume_ign", 32'(state), 32'h3);
        resume = 1'b0;

        // Halt, drain three cycles, resume
        reset_dut();
        id_halt = 1'b1;
        cyc();
        id_halt = 1'b0;
        chk("hd_state", 32'(state), 32'h2);
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("hd_en_d%0d", i), 32'(en_v), 32'h07);
            chk($sformatf("hd_bub_d%0d", i), 32'(idex_bubble), 32'h1);
            cyc();
            chk($sformatf("hd_state_d%0d", i), 32'(state),
                (i == 3) ? 32'h3 : 32'h2);
        end
        chk("hd_halted", 32'(halted), 32'h1);
        #1;
        chk("hd_halt_en", 32'(en_v), 32'h00);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("hd_resume", 32'(state), 32'h0);
        chk("hd_halted_clr", 32'(halted), 32'h0);

        // Drain with memory busy mid-drain
        reset_dut();
        id_halt = 1'b1;
        cyc();
        id_halt = 1'b0;
        cyc();
        chk("db_state_a", 32'(state), 32'h2);
        mem_busy = 1'b1;
        #1;
        chk("db_busy_en", 32'(en_v), 32'h00);
        cyc();
        cyc();
        chk("db_state_b", 32'(state), 32'h2);
        mem_busy = 1'b0;
        cyc();
        chk("db_state_c", 32'(state), 32'h2);
        cyc();
        chk("db_state_d", 32'(state), 32'h3);
        chk("db_stall", 32'(stall_cnt), 32'h0);

        // Counter saturation
        reset_dut();
        set_lu();
        for (int i = 0; i < 70000; i++) cyc();
        chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
        chk("sat_lu_state", 32'(state), 32'h0);
        idle();
        branch_taken = 1'b1;
        for (int i = 0; i < 300; i++) cyc();
        branch_taken = 1'b0;
        chk("sat_flush", 32'(flush_cnt), 32'hFF);
        chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
